// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and default widths for the data-memory arbiter.
//   arb_state_e : IDLE / ISSUE / WAIT / ACK access sequencer states
//   owner_e     : which requester owns the current (or last) access
package dmem_arb_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both requester handshakes and the DMEM bus.
//   slave  : the arbiter's view (requests in, acks/rdata/memory bus out)
//   master : the surrounding system's view (CPU FSM, debug port, DMEM)
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = dmem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = dmem_arb_pkg::DATA_W
);

  logic              run;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport slave (
    input  run, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output cpu_ack, dbg_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, owner
  );

  modport master (
    output run, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  cpu_ack, dbg_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, owner
  );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// arb_starve_counter: counts consecutive CPU grants taken while a debug
// request was waiting; saturates at DBG_WAIT_MAX.
//   clock, reset_n : system clock, async active-low reset
//   inc            : CPU granted while debug pending
//   clr            : debug granted, or debug not requesting in IDLE
//   sat            : count has reached DBG_WAIT_MAX
module arb_starve_counter #(
  parameter int unsigned DBG_WAIT_MAX = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat = (cnt_q == CNT_W'(DBG_WAIT_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 16x8 DMEM between the multicycle CPU
// and the debug loader/viewer. Fixed 4-cycle sequence IDLE->ISSUE->WAIT->ACK;
// CPU wins ties unless the CPU is halted or the debug side has been passed
// over DBG_WAIT_MAX times in a row.
//   clock, reset_n : system clock, async active-low reset
//   bus (slave)    : run, cpu_*/dbg_* handshakes, rdata, mem_* bus,
//                    busy, owner
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = dmem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W       = dmem_arb_pkg::DATA_W,
  parameter int unsigned DBG_WAIT_MAX = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  dmem_arbiter_if.slave bus
);

  import dmem_arb_pkg::*;

  arb_state_e        state_q;
  owner_e            owner_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              cpu_ack_q;
  logic              dbg_ack_q;

  logic in_idle;
  logic any_req;
  logic pick_dbg;
  logic starve_sat;
  logic starve_inc;
  logic starve_clr;

  always_comb begin
    in_idle    = (state_q == IDLE);
    any_req    = bus.cpu_req || bus.dbg_req;
    // Debug wins when alone, when the CPU is halted, or once starved.
    pick_dbg   = bus.dbg_req && (!bus.cpu_req || !bus.run || starve_sat);
    starve_inc = in_idle && bus.cpu_req && bus.dbg_req && !pick_dbg;
    starve_clr = in_idle && (!bus.dbg_req || pick_dbg);
  end

  arb_starve_counter #(
    .DBG_WAIT_MAX (DBG_WAIT_MAX)
  ) u_starve (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .sat     (starve_sat)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
    end else begin
      mem_en_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q  <= ISSUE;
            mem_en_q <= 1'b1;
            if (pick_dbg) begin
              owner_q     <= OWN_DBG;
              mem_we_q    <= bus.dbg_we;
              mem_addr_q  <= bus.dbg_addr;
              mem_wdata_q <= bus.dbg_wdata;
            end else begin
              owner_q     <= OWN_CPU;
              mem_we_q    <= bus.cpu_we;
              mem_addr_q  <= bus.cpu_addr;
              mem_wdata_q <= bus.cpu_wdata;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          state_q <= ACK;
          if (!mem_we_q) begin
            rdata_q <= bus.mem_rdata;
          end
          if (owner_q == OWN_DBG) begin
            dbg_ack_q <= 1'b1;
          end else begin
            cpu_ack_q <= 1'b1;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.busy      = !in_idle;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned WMAX = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .DBG_WAIT_MAX (WMAX)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Synchronous 16x8 data memory with a preload port.
  logic [DW-1:0] mem [16];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  function automatic logic [7:0] init_val(input int i);
    if (i == 3) return 8'h5A;
    return 8'(i * 29 + 7);
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Reference model: age = edges since the grant (0 = free for a new grant).
  int          m_age = 0;
  int          m_starve = 0;
  logic        m_own = 1'b0;
  logic        m_we = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_rdata = '0;
  logic [7:0]  mm [16];
  logic        obs_own [$];

  task automatic model_reset();
    m_age = 0; m_starve = 0; m_own = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  // Advance the model across the next rising edge, then check the DUT.
  task automatic step();
    logic g_dbg;
    if (m_age == 0) begin
      if (bus.cpu_req || bus.dbg_req) begin
        g_dbg = bus.dbg_req && (!bus.cpu_req || !bus.run || m_starve == int'(WMAX));
        if (g_dbg || !bus.dbg_req) m_starve = 0;
        else if (m_starve < int'(WMAX)) m_starve++;
        m_own   = g_dbg;
        m_we    = g_dbg ? bus.dbg_we    : bus.cpu_we;
        m_addr  = g_dbg ? bus.dbg_addr  : bus.cpu_addr;
        m_wdata = g_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        m_age   = 1;
      end else begin
        m_starve = 0;
      end
    end else if (m_age == 1) begin
      if (m_we) mm[m_addr] = m_wdata;
      m_age = 2;
    end else if (m_age == 2) begin
      if (!m_we) m_rdata = mm[m_addr];
      m_age = 3;
    end else begin
      m_age = 0;
    end
    @(posedge clock); #1;
    chk("mem_en", bus.mem_en, m_age == 1);
    if (m_age == 1) begin
      chk("mem_we", bus.mem_we, m_we);
      chk("mem_addr", bus.mem_addr, m_addr);
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
    chk("cpu_ack", bus.cpu_ack, m_age == 3 && !m_own);
    chk("dbg_ack", bus.dbg_ack, m_age == 3 && m_own);
    chk("busy", bus.busy, m_age != 0);
    chk("owner", bus.owner, m_own);
    if (m_age == 3) chk("rdata", bus.rdata, m_rdata);
    if (bus.mem_en) obs_own.push_back(bus.owner);
  endtask

  // One access from an idle arbiter; returns the ack latency (0 = none).
  task automatic access(input bit dbg, input bit we, input logic [3:0] addr,
                        input logic [7:0] wd, input int chg_addr,
                        output logic [7:0] rd, output int lat);
    logic ack;
    if (dbg) begin
      bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
    lat = 0;
    rd  = '0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (chg_addr >= 0) begin
        chk("hold_addr", bus.mem_addr, addr);
        if (n == 1) bus.cpu_addr = 4'(chg_addr);
      end
      ack = dbg ? bus.dbg_ack : bus.cpu_ack;
      if (ack) begin
        rd  = bus.rdata;
        lat = n;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    step();
  endtask

  logic [7:0] rd;
  int         lat;
  logic       exp_ord [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    bus.run = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.mem_rdata = '0;

    // Preload memory while reset is held.
    for (int i = 0; i < 16; i++) begin
      pl_en = 1'b1; pl_addr = 4'(i); pl_data = init_val(i);
      mm[i] = init_val(i);
      @(posedge clock); #1;
    end
    pl_en = 1'b0;

    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_cpu_ack", bus.cpu_ack, 1'b0);
    chk("rst_dbg_ack", bus.dbg_ack, 1'b0);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_mem_addr", bus.mem_addr, 4'h0);
    chk("rst_owner", bus.owner, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    reset_n = 1'b1;
    model_reset();

    // CPU read alone.
    access(1'b0, 1'b0, 4'd3, 8'h00, -1, rd, lat);
    chk("cpu_rd_lat", lat, 3);
    chk("cpu_rd_data", rd, 8'h5A);

    // Debug write, then CPU read back; write ack keeps old rdata.
    access(1'b1, 1'b1, 4'd7, 8'hC3, -1, rd, lat);
    chk("dbg_wr_lat", lat, 3);
    chk("dbg_wr_rdata_kept", rd, 8'h5A);
    access(1'b0, 1'b0, 4'd7, 8'h00, -1, rd, lat);
    chk("cpu_rd7_data", rd, 8'hC3);

    // Both requesting continuously, CPU running: starvation guard.
    obs_own.delete();
    bus.run = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'd1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 4'd4;
    repeat (28) step();
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    step();
    chk("order_len", obs_own.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("order_%0d", i), (obs_own.size() > i) ? obs_own[i] : 1'bx, exp_ord[i]);

    // CPU halted: debug first, then CPU.
    obs_own.delete();
    bus.run = 1'b0;
    bus.cpu_req = 1'b1; bus.dbg_req = 1'b1;
    for (int n = 0; n < 20 && (bus.cpu_req || bus.dbg_req); n++) begin
      step();
      if (bus.dbg_ack) bus.dbg_req = 1'b0;
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
    end
    step();
    chk("halt_len", obs_own.size(), 2);
    chk("halt_first", (obs_own.size() > 0) ? obs_own[0] : 1'bx, 1'b1);
    chk("halt_second", (obs_own.size() > 1) ? obs_own[1] : 1'bx, 1'b0);
    bus.run = 1'b1;

    // Reset during ISSUE of a CPU write.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 4'd5; bus.cpu_wdata = 8'hEE;
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_mem_en", bus.mem_en, 1'b0);
    chk("arst_mem_we", bus.mem_we, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_mem_wdata", bus.mem_wdata, 8'h00);
    bus.cpu_req = 1'b0;
    model_reset();
    @(posedge clock); #1;
    chk("arst_no_ack", bus.cpu_ack, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    access(1'b0, 1'b0, 4'd5, 8'h00, -1, rd, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", rd, init_val(5));

    // Address change after grant is ignored.
    access(1'b0, 1'b0, 4'd2, 8'h00, 9, rd, lat);
    chk("chg_lat", lat, 3);
    chk("chg_data", rd, init_val(2));

    // Randomized traffic from both sides.
    for (int c = 0; c < 3000; c++) begin
      if (bus.cpu_ack) begin
        bus.cpu_req = ($urandom_range(0, 2) != 0);
        bus.cpu_we = 1'($urandom); bus.cpu_addr = 4'($urandom); bus.cpu_wdata = 8'($urandom);
      end else if (!bus.cpu_req) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.cpu_req = 1'b1;
          bus.cpu_we = 1'($urandom); bus.cpu_addr = 4'($urandom); bus.cpu_wdata = 8'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.cpu_addr = 4'($urandom); bus.cpu_wdata = 8'($urandom);
      end
      if (bus.dbg_ack) begin
        bus.dbg_req = ($urandom_range(0, 2) != 0);
        bus.dbg_we = 1'($urandom); bus.dbg_addr = 4'($urandom); bus.dbg_wdata = 8'($urandom);
      end else if (!bus.dbg_req) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.dbg_req = 1'b1;
          bus.dbg_we = 1'($urandom); bus.dbg_addr = 4'($urandom); bus.dbg_wdata = 8'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.dbg_addr = 4'($urandom); bus.dbg_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 63) == 0) bus.run = ~bus.run;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
